// File: rtl/run_detector.sv
// run_detector: samples a serial bit on qualified cycles, tracks the current
// run length (repeated value, or alternating values in mode 11) in a
// saturating counter, raises a Moore flag once the programmed run length is
// reached, and emits one registered pulse per run while counting detections.
module run_detector #(
  parameter int RUN_MAX = 8,
  parameter int CNT_W   = 4,
  parameter int HIT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] State,
  output logic             last_bit,
  output logic             z,
  output logic             match,
  output logic [HIT_W-1:0] hits
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [HIT_W-1:0] HIT_ONE = HIT_W'(1);
  localparam logic [HIT_W-1:0] HIT_SAT = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             match_q, match_d;
  logic [HIT_W-1:0] hits_q, hits_d;

  logic [CNT_W-1:0] rl;
  logic             z_cur;
  logic             z_next;
  logic             extend;

  // Detect condition for a given counter/last-bit pair under the current
  // mode and effective threshold. cnt==0 means no history, never a detect.
  function automatic logic detect(input logic [CNT_W-1:0] c,
                                  input logic             lb,
                                  input logic [1:0]       m,
                                  input logic [CNT_W-1:0] thr);
    logic qual;
    case (m)
      2'b00:   qual = lb;
      2'b01:   qual = ~lb;
      default: qual = 1'b1;
    endcase
    return qual && (c >= thr) && (c != '0);
  endfunction

  // Effective threshold: run_len clamped into 1..RUN_MAX.
  always_comb begin
    rl = run_len;
    if (run_len == '0) begin
      rl = CNT_ONE;
    end else if (run_len > CNT_MAX) begin
      rl = CNT_MAX;
    end
  end

  // Next-state: run counter, last bit, detection pulse and hit counter.
  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    hits_d  = hits_q;
    match_d = 1'b0;
    extend  = 1'b0;
    z_cur   = detect(cnt_q, last_q, mode, rl);
    z_next  = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      last_d = 1'b0;
      hits_d = '0;
    end else if (en) begin
      last_d = w;
      if (cnt_q == '0) begin
        cnt_d = CNT_ONE;
      end else begin
        // Alternating mode extends on a change; other modes on a repeat.
        extend = (mode == 2'b11) ? (w != last_q) : (w == last_q);
        if (!extend) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = CNT_MAX;
        end
      end
      // Pulse only on the rising edge of the detect flag: one per run.
      z_next  = detect(cnt_d, last_d, mode, rl);
      match_d = z_next && !z_cur;
      if (match_d && (hits_q != HIT_SAT)) begin
        hits_d = hits_q + HIT_ONE;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      last_q  <= 1'b0;
      match_q <= 1'b0;
      hits_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      match_q <= match_d;
      hits_q  <= hits_d;
    end
  end

  assign State    = cnt_q;
  assign last_bit = last_q;
  assign z        = z_cur;
  assign match    = match_q;
  assign hits     = hits_q;

endmodule

// File: tb/tb_run_detector.sv
// Testbench for run_detector: directed vectors with hand-computed results.
// The driver pushes the expected post-edge outputs into a queue; a monitor
// pops one entry after each clock edge and compares. A second instance with a
// 2-bit hit counter runs on the same stimulus to exercise hit saturation.
module tb_run_detector;

  localparam int EXP_W = 15;  // {State[3:0], last_bit, z, match, hits[7:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       w;
  logic       clr;
  logic [1:0] mode;
  logic [3:0] run_len;

  logic [3:0] st_a;
  logic       lb_a, z_a, m_a;
  logic [7:0] hits_a;
  logic [3:0] st_b;
  logic       lb_b, z_b, m_b;
  logic [1:0] hits_b;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  logic [1:0]       mon_h2;

  int checks = 0;
  int errors = 0;

  run_detector #(.RUN_MAX(8), .CNT_W(4), .HIT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .clr(clr), .mode(mode),
    .run_len(run_len), .State(st_a), .last_bit(lb_a), .z(z_a),
    .match(m_a), .hits(hits_a)
  );

  run_detector #(.RUN_MAX(8), .CNT_W(4), .HIT_W(2)) dut_h (
    .clk(clk), .reset(reset), .en(en), .w(w), .clr(clr), .mode(mode),
    .run_len(run_len), .State(st_b), .last_bit(lb_b), .z(z_b),
    .match(m_b), .hits(hits_b)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input logic s_en, input logic s_w, input logic s_clr,
                      input logic [1:0] s_mode, input logic [3:0] s_rl,
                      input logic [3:0] x_st, input logic x_lb, input logic x_z,
                      input logic x_m, input logic [7:0] x_h);
    @(negedge clk);
    en      = s_en;
    w       = s_w;
    clr     = s_clr;
    mode    = s_mode;
    run_len = s_rl;
    exp_q.push_back({x_st, x_lb, x_z, x_m, x_h});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " State"}, 32'(st_a), 0);
    check({tag, " last_bit"}, 32'(lb_a), 0);
    check({tag, " z"}, 32'(z_a), 0);
    check({tag, " match"}, 32'(m_a), 0);
    check({tag, " hits"}, 32'(hits_a), 0);
    check({tag, " hits_h"}, 32'(hits_b), 0);
  endtask

  // Monitor: one queued expectation per clock edge, compared after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_h2 = (mon_e[7:0] > 8'd3) ? 2'd3 : mon_e[1:0];
      check("State", 32'(st_a), 32'(mon_e[14:11]));
      check("last_bit", 32'(lb_a), 32'(mon_e[10]));
      check("z", 32'(z_a), 32'(mon_e[9]));
      check("match", 32'(m_a), 32'(mon_e[8]));
      check("hits", 32'(hits_a), 32'(mon_e[7:0]));
      check("State_h", 32'(st_b), 32'(mon_e[14:11]));
      check("last_bit_h", 32'(lb_b), 32'(mon_e[10]));
      check("z_h", 32'(z_b), 32'(mon_e[9]));
      check("match_h", 32'(m_b), 32'(mon_e[8]));
      check("hits_h", 32'(hits_b), 32'(mon_h2));
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    reset = 1'b0; en = 1'b0; w = 1'b0; clr = 1'b0; mode = 2'b00; run_len = 4'd3;
    #12;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b1;

    // Run of ones, threshold 3
    step(1, 1, 0, 2'b00, 4'd3, 4'd1, 1, 0, 0, 8'd0);
    step(1, 1, 0, 2'b00, 4'd3, 4'd2, 1, 0, 0, 8'd0);
    step(1, 1, 0, 2'b00, 4'd3, 4'd3, 1, 1, 1, 8'd1);
    step(1, 1, 0, 2'b00, 4'd3, 4'd4, 1, 1, 0, 8'd1);
    step(1, 0, 0, 2'b00, 4'd3, 4'd1, 0, 0, 0, 8'd1);

    // Run of zeros, threshold 2, two detections
    step(1, 1, 1, 2'b01, 4'd2, 4'd0, 0, 0, 0, 8'd0);
    step(1, 0, 0, 2'b01, 4'd2, 4'd1, 0, 0, 0, 8'd0);
    step(1, 0, 0, 2'b01, 4'd2, 4'd2, 0, 1, 1, 8'd1);
    step(1, 1, 0, 2'b01, 4'd2, 4'd1, 1, 0, 0, 8'd1);
    step(1, 0, 0, 2'b01, 4'd2, 4'd1, 0, 0, 0, 8'd1);
    step(1, 0, 0, 2'b01, 4'd2, 4'd2, 0, 1, 1, 8'd2);

    // Alternating run, threshold 4
    step(0, 0, 1, 2'b11, 4'd4, 4'd0, 0, 0, 0, 8'd0);
    step(1, 0, 0, 2'b11, 4'd4, 4'd1, 0, 0, 0, 8'd0);
    step(1, 1, 0, 2'b11, 4'd4, 4'd2, 1, 0, 0, 8'd0);
    step(1, 0, 0, 2'b11, 4'd4, 4'd3, 0, 0, 0, 8'd0);
    step(1, 1, 0, 2'b11, 4'd4, 4'd4, 1, 1, 1, 8'd1);
    step(1, 1, 0, 2'b11, 4'd4, 4'd1, 1, 0, 0, 8'd1);

    // Saturation with run_len above RUN_MAX, either-value mode
    step(0, 0, 1, 2'b10, 4'd15, 4'd0, 0, 0, 0, 8'd0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, 0, 2'b10, 4'd15, (i >= 8) ? 4'd8 : 4'(i), 1, (i >= 8), (i == 8),
           (i >= 8) ? 8'd1 : 8'd0);
    end
    // Mode changes without en: z follows combinationally, no pulse
    step(0, 0, 0, 2'b01, 4'd15, 4'd8, 1, 0, 0, 8'd1);
    step(0, 0, 0, 2'b10, 4'd15, 4'd8, 1, 1, 0, 8'd1);

    // en gating then clear
    step(0, 0, 1, 2'b00, 4'd2, 4'd0, 0, 0, 0, 8'd0);
    step(1, 1, 0, 2'b00, 4'd2, 4'd1, 1, 0, 0, 8'd0);
    step(0, 1, 0, 2'b00, 4'd2, 4'd1, 1, 0, 0, 8'd0);
    step(1, 1, 0, 2'b00, 4'd2, 4'd2, 1, 1, 1, 8'd1);
    step(1, 1, 1, 2'b00, 4'd2, 4'd0, 0, 0, 0, 8'd0);

    // Threshold of 1 via run_len 0
    step(1, 1, 0, 2'b00, 4'd0, 4'd1, 1, 1, 1, 8'd1);
    step(1, 0, 0, 2'b00, 4'd0, 4'd1, 0, 0, 0, 8'd1);
    step(1, 1, 0, 2'b00, 4'd0, 4'd1, 1, 1, 1, 8'd2);

    // Five detections, then asynchronous reset mid-run
    step(0, 0, 1, 2'b00, 4'd2, 4'd0, 0, 0, 0, 8'd0);
    for (int r = 1; r <= 5; r++) begin
      step(1, 1, 0, 2'b00, 4'd2, 4'd1, 1, 0, 0, 8'(r - 1));
      step(1, 1, 0, 2'b00, 4'd2, 4'd2, 1, 1, 1, 8'(r));
      if (r < 5) step(1, 0, 0, 2'b00, 4'd2, 4'd1, 0, 0, 0, 8'(r));
    end
    @(negedge clk);
    check("pre-reset z", 32'(z_a), 1);
    check("pre-reset hits", 32'(hits_a), 5);
    #2;
    reset = 1'b0;
    en    = 1'b0;
    #1;
    check_cleared("async reset");
    @(negedge clk);
    reset = 1'b1;
    step(1, 1, 0, 2'b00, 4'd2, 4'd1, 1, 0, 0, 8'd0);

    // Six runs of two ones: narrow hit counter saturates at 3
    step(0, 0, 1, 2'b00, 4'd2, 4'd0, 0, 0, 0, 8'd0);
    for (int r = 1; r <= 6; r++) begin
      step(1, 1, 0, 2'b00, 4'd2, 4'd1, 1, 0, 0, 8'(r - 1));
      step(1, 1, 0, 2'b00, 4'd2, 4'd2, 1, 1, 1, 8'(r));
      step(1, 0, 0, 2'b00, 4'd2, 4'd1, 0, 0, 0, 8'(r));
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
- Parametrised successor to the team's fixed binary-encoded sequence FSM.
- Samples a serial bit `w` on qualified cycles and tracks the current run length (same value repeated, or alternating values in alternate mode) in a saturating counter.
- Flags when a programmable run length is reached, and counts detections.
- Sits between the input synchroniser/debouncer and the display/LED logic in the lab top level.

Parameters:
- RUN_MAX, 8: saturation value of the run counter; legal 2..255.
- CNT_W, 4: width of `State` and `run_len`; must satisfy 2^CNT_W > RUN_MAX.
- HIT_W, 8: width of the saturating detection counter `hits`.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately, independent of clk).
- en  in  1  sample qualifier; `w` is consumed only on cycles with en==1.
- w  in  1  serial input bit.
- clr  in  1  synchronous clear of run history and `hits`; priority over en.
- mode  in  2  00 run of ones, 01 run of zeros, 10 run of either value, 11 alternating run.
- run_len  in  CNT_W  detection threshold; effective value rl = clamp(run_len, 1, RUN_MAX).
- State  out  CNT_W  current run counter value.
- last_bit  out  1  most recently sampled `w`.
- z  out  1  Moore detect flag.
- match  out  1  one-cycle detection pulse, registered.
- hits  out  HIT_W  number of detections, saturating.

Behaviour:
- Registers: cnt (CNT_W), last_bit, match, hits.
- Reset (async, reset==0): cnt=0, last_bit=0, match=0, hits=0, therefore z=0.
- cnt==0 means no history.
- clr==1 at a clock edge: cnt=0, last_bit=0, match=0, hits=0; en is ignored that cycle.
- en==0, clr==0: cnt, last_bit and hits hold; match=0.
- en==1, clr==0, cnt==0: cnt=1, last_bit=w.
- en==1, clr==0, cnt>0, modes 00/01/10:
  - w==last_bit: cnt=min(cnt+1, RUN_MAX).
  - w!=last_bit: cnt=1.
  - In all cases last_bit=w.
- en==1, clr==0, cnt>0, mode 11:
  - w!=last_bit: cnt=min(cnt+1, RUN_MAX).
  - w==last_bit: cnt=1.
  - In all cases last_bit=w.
- qual(cnt, last_bit, mode):
  - mode 00: last_bit==1.
  - mode 01: last_bit==0.
  - mode 10 and 11: 1.
- z = qual & (cnt >= rl) & (cnt != 0). z is purely combinational from registered state, mode and run_len, so it responds to mode/run_len changes the same cycle.
- match is registered: match=1 in the cycle after an en edge where z_next==1 and z_current==0, both evaluated with the current mode/run_len; otherwise 0.
- Detection is overlap-free: match fires once per run. A run continuing past rl or saturating at RUN_MAX keeps z high with no further pulses. A break followed by a new run re-arms detection.
- hits increments together with match, saturates at 2^HIT_W-1, and never wraps.
- rl==1 (run_len 0 or 1): z=1 on any qualifying sample, and match fires when z rises.
- run_len > RUN_MAX: treated as RUN_MAX. A saturated run then satisfies z indefinitely.
- Mode/run_len change with en==0: z may change combinationally; match stays 0 (pulses only on en cycles).
- Latency: `w` sampled at edge k is reflected in State/last_bit/z after edge k, and in match/hits at the same edge.
- Reset asserted mid-run: all outputs go to reset values asynchronously. The first en sample after release starts a new run at cnt=1.

Test Plan:
- Reset, then mode=00, run_len=3, en=1, w=1,1,1,1,0 -> State 1,2,3,4,1; z 0,0,1,1,0; match high only after the 3rd edge; hits=1.
- mode=01, run_len=2, w=0,0,1,0,0 -> z rises after edges 2 and 5, match pulses twice, hits=2; State ends at 2.
- mode=11, run_len=4, w=0,1,0,1,1 -> State 1,2,3,4,1; z high after edge 4 only; hits=1.
- Saturation: RUN_MAX=8, run_len=15, mode=10, twelve w=1 samples -> State stops at 8; z=1 from edge 8 on; exactly one match.
- en gating and clr: en toggling 1,0,1 with w=1 and run_len=2 -> State holds across the en=0 cycle and z rises on the 2nd en edge. Then clr=1 with en=1 -> State=0, hits=0, match=0 the next cycle.
- Async reset: assert reset=0 between clock edges while z=1 and hits=5 -> outputs clear with no clk edge. Release, then w=1 -> State=1.
- hits saturation: HIT_W=2, six separate length-2 runs of ones (run_len=2, mode=00) -> hits 1,2,3,3,3,3; match still pulses each time.
